pixel_array_ctrl: RTL
=====================

# pixel_array_ctrl

- Synchronous controller that drives the pixel sensor array through a full frame: erase, expose, ramp conversion, then row-by-row readout.
- Sources the ERASE, EXPOSE, VBN1, RAMP, COUNTER and per-row READ signals.
- Captures each row from the shared tristated DATA buses and streams pixels out over a valid/ready interface.
- Sits between the sensor array and the downstream frame sink.

## Interface

Parameters:
- PIXEL_BITS, from PixelSensorConfig (8): pixel/counter width.
- PIXEL_ARRAY_WIDTH, from PixelSensorConfig (2): columns, one DATA bus per column.
- PIXEL_ARRAY_HEIGHT, from PixelSensorConfig (2): rows, one READ line per row.
- ERASE_CYCLES, 5: cycles ERASE is held high.
- EXPOSE_CYCLES, 255: cycles EXPOSE is held high.

Ports (one clock; reset is synchronous and active-low):
- clk  in  1  system clock, all logic on posedge.
- reset  in  1  synchronous, active-low.
- start  in  1  begin a frame; sampled only in IDLE.
- busy  out  1  high in every state except IDLE.
- erase  out  1  to sensor ERASE.
- expose  out  1  to sensor EXPOSE.
- vbn1  out  1  integration clock to sensor VBN1.
- ramp  out  1  to sensor RAMP.
- counter  out  PIXEL_BITS  to sensor COUNTER.
- read  out  PIXEL_ARRAY_HEIGHT  one-hot row select, all-zero when not reading.
- data_in  in  PIXEL_ARRAY_WIDTH*PIXEL_BITS  column buses; column c is at bits [c*PIXEL_BITS +: PIXEL_BITS].
- pix_valid  out  1  pixel available.
- pix_ready  in  1  sink accepts pixel.
- pix_data  out  PIXEL_BITS  pixel value.
- pix_row  out  $clog2(HEIGHT)  row index of pix_data.
- pix_col  out  $clog2(WIDTH)  column index of pix_data.
- pix_last  out  1  high with the final pixel of the frame.
- frame_done  out  1  one-cycle pulse after the last transfer.

## Operation

States and transitions:
- IDLE: start=1 moves to ERASE; otherwise stay.
- ERASE: erase=1 for ERASE_CYCLES cycles, then EXPOSE.
- EXPOSE: expose=1 for EXPOSE_CYCLES cycles. vbn1 toggles every cycle, starting 0 → 1 on the first EXPOSE cycle. Then CONVERT.
- CONVERT: 2^PIXEL_BITS steps, then ROW_SEL with row=0.
- ROW_SEL: read[row]=1 for one cycle (bus settle).
- ROW_CAP: read[row] stays 1. On this edge, data_in is captured into the row buffer.
- STREAM: read=0. Columns 0..WIDTH-1 are offered in order.
  - After the last column: if row<HEIGHT-1, row+1 and go to ROW_SEL; otherwise pulse frame_done and go to IDLE.

Idle values of sensor-side outputs:
- erase, expose, vbn1 and ramp are 0 outside their own states.
- counter is 0 outside CONVERT.

Stream handshake:
- A transfer occurs on a cycle where pix_valid=1 and pix_ready=1.
- While pix_valid=1 and pix_ready=0, pix_data, pix_row, pix_col and pix_last are held stable.
- pix_valid never drops without a transfer.

Arithmetic:
- The step counter is PIXEL_BITS+1 bits wide, so the terminal count does not overflow.
- counter is its low PIXEL_BITS bits.
- No wrap occurs inside a frame.

Boundary conditions:
- start while busy: ignored, no queuing.
- start held high continuously: the next frame begins the cycle after frame_done.
- reset=0 at any point: on that edge, all outputs return to reset values and the FSM goes to IDLE. A partial frame is discarded and no frame_done is issued.
- pix_ready held low indefinitely: the FSM stalls in STREAM with read=0.

## Timing

Reset values:
- All outputs 0, read all-zero, FSM in IDLE.

Start latency:
- start sampled high in IDLE → erase=1 on the next cycle.

CONVERT step k (k=0..2^PIXEL_BITS-1):
- Occupies CONVERT cycles 2k and 2k+1.
- counter=k during both cycles.
- ramp=1 only on cycle 2k+1, so counter is stable one full cycle before each ramp rising edge.
- Total CONVERT duration is 2^(PIXEL_BITS+1) cycles. On exit, ramp=0 and counter=0.

Readout:
- ROW_SEL and ROW_CAP take 1 cycle each.
- The first pix_valid of a row is asserted in the first STREAM cycle.
- With pix_ready held 1, one pixel transfers per cycle.

Frame end:
- frame_done=1 on the cycle after the pix_last transfer, coincident with re-entry to IDLE; busy=0 on that same cycle.

## Structure

- PixelSensorConfig holds PIXEL_BITS, PIXEL_ARRAY_WIDTH and PIXEL_ARRAY_HEIGHT.
- Add to PixelSensorConfig:
  - enum typedef pixel_ctrl_state_t (IDLE, ERASE, EXPOSE, CONVERT, ROW_SEL, ROW_CAP, STREAM).
  - Default constants PIXEL_ERASE_CYCLES and PIXEL_EXPOSE_CYCLES.
- One sub-module, pixel_row_buffer:
  - Width-parameterised register array with capture enable and column-select read port.
  - Holds one row of pixels.
- FSM, timers and handshake stay in pixel_array_ctrl.

## Test plan

- Reset/idle: reset=0 for 3 cycles, then start=0 for 20 cycles → all outputs 0, busy=0, read=0.
- Sequencing, ERASE_CYCLES=5, EXPOSE_CYCLES=255:
  - pulse start → erase high for exactly 5 cycles, then expose high for 255 cycles with vbn1 toggling;
  - then 512 CONVERT cycles with ramp high on odd cycles only and counter=0..255;
  - counter must equal ramp step index at every ramp rise.
- Full frame, 2x2 array of PIXEL_SENSOR models (SCENE {{10,20},{30,40}}), pix_ready=1:
  - exactly 4 transfers ordered (0,0),(0,1),(1,0),(1,1);
  - values match the sensor latches;
  - pix_last only on (1,1); frame_done one cycle later.
- Back-pressure: pix_ready toggled with a 1-in-3 pattern → outputs stable while stalled, no pixel lost or duplicated, read=0 during stalls.
- Start while busy: start pulsed mid-CONVERT → no effect, exactly one frame_done.
- Mid-frame reset: reset=0 during STREAM row 0 → next edge all outputs 0 and IDLE, no frame_done; a following start produces a complete, correct frame.

Source files
------------

// File: rtl/pixel_array_ctrl_pkg.sv
// Pixel sensor configuration (PixelSensorConfig): array geometry, default
// phase lengths and the controller state encoding.
package pixel_array_ctrl_pkg;

  localparam int PIXEL_BITS          = 8;
  localparam int PIXEL_ARRAY_WIDTH   = 2;
  localparam int PIXEL_ARRAY_HEIGHT  = 2;
  localparam int PIXEL_ERASE_CYCLES  = 5;
  localparam int PIXEL_EXPOSE_CYCLES = 255;

  typedef enum logic [2:0] {
    IDLE,
    ERASE,
    EXPOSE,
    CONVERT,
    ROW_SEL,
    ROW_CAP,
    STREAM
  } pixel_ctrl_state_t;

endpackage

// File: rtl/pixel_array_ctrl_row_buffer.sv
// One row of captured pixels, loaded in parallel from the column buses
// and read back one column at a time.
module pixel_row_buffer #(
  parameter int PIXEL_BITS = pixel_array_ctrl_pkg::PIXEL_BITS,
  parameter int WIDTH      = pixel_array_ctrl_pkg::PIXEL_ARRAY_WIDTH
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        i_capture,
  input  logic [WIDTH*PIXEL_BITS-1:0] i_rowData,
  input  logic [$clog2(WIDTH)-1:0]    i_col,
  output logic [PIXEL_BITS-1:0]       o_pixel
);

  logic [PIXEL_BITS-1:0] r_pixels [WIDTH];

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int c = 0; c < WIDTH; c++) r_pixels[c] <= '0;
    end else if (i_capture) begin
      for (int c = 0; c < WIDTH; c++) r_pixels[c] <= i_rowData[c*PIXEL_BITS +: PIXEL_BITS];
    end
  end

  assign o_pixel = r_pixels[i_col];

endmodule

// File: rtl/pixel_array_ctrl.sv
// Frame sequencer for the pixel sensor array: erase, expose, ramp conversion,
// then row-by-row readout streamed over a valid/ready port.
module pixel_array_ctrl #(
  parameter int PIXEL_BITS         = pixel_array_ctrl_pkg::PIXEL_BITS,
  parameter int PIXEL_ARRAY_WIDTH  = pixel_array_ctrl_pkg::PIXEL_ARRAY_WIDTH,
  parameter int PIXEL_ARRAY_HEIGHT = pixel_array_ctrl_pkg::PIXEL_ARRAY_HEIGHT,
  parameter int ERASE_CYCLES       = pixel_array_ctrl_pkg::PIXEL_ERASE_CYCLES,
  parameter int EXPOSE_CYCLES      = pixel_array_ctrl_pkg::PIXEL_EXPOSE_CYCLES
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      start,
  output logic                                      busy,
  output logic                                      erase,
  output logic                                      expose,
  output logic                                      vbn1,
  output logic                                      ramp,
  output logic [PIXEL_BITS-1:0]                     counter,
  output logic [PIXEL_ARRAY_HEIGHT-1:0]             read,
  input  logic [PIXEL_ARRAY_WIDTH*PIXEL_BITS-1:0]   data_in,
  output logic                                      pix_valid,
  input  logic                                      pix_ready,
  output logic [PIXEL_BITS-1:0]                     pix_data,
  output logic [$clog2(PIXEL_ARRAY_HEIGHT)-1:0]     pix_row,
  output logic [$clog2(PIXEL_ARRAY_WIDTH)-1:0]      pix_col,
  output logic                                      pix_last,
  output logic                                      frame_done
);

  import pixel_array_ctrl_pkg::*;

  localparam int ROW_W   = $clog2(PIXEL_ARRAY_HEIGHT);
  localparam int COL_W   = $clog2(PIXEL_ARRAY_WIDTH);
  localparam int MAX_CYC = (ERASE_CYCLES > EXPOSE_CYCLES) ? ERASE_CYCLES : EXPOSE_CYCLES;
  localparam int TIMER_W = $clog2(MAX_CYC + 1);
  localparam logic [PIXEL_BITS:0] CONVERT_STEPS = {1'b1, {PIXEL_BITS{1'b0}}};

  pixel_ctrl_state_t               r_state;
  logic [TIMER_W-1:0]              r_timer;
  logic [PIXEL_BITS:0]             r_step;
  logic                            r_phase;
  logic [ROW_W-1:0]                r_row;
  logic [COL_W-1:0]                r_col;
  logic                            r_erase;
  logic                            r_expose;
  logic                            r_vbn1;
  logic [PIXEL_ARRAY_HEIGHT-1:0]   r_read;
  logic                            r_pixValid;
  logic                            r_pixLast;
  logic                            r_frameDone;

  logic [PIXEL_BITS:0]             w_stepNext;
  logic [ROW_W-1:0]                w_rowNext;
  logic [COL_W-1:0]                w_colNext;
  logic                            w_lastRow;
  logic                            w_lastCol;
  logic                            w_capture;
  logic [PIXEL_BITS-1:0]           w_bufPixel;

  assign w_stepNext = r_step + 1'b1;
  assign w_rowNext  = r_row + 1'b1;
  assign w_colNext  = r_col + 1'b1;
  assign w_lastRow  = (r_row == ROW_W'(PIXEL_ARRAY_HEIGHT - 1));
  assign w_lastCol  = (r_col == COL_W'(PIXEL_ARRAY_WIDTH - 1));
  assign w_capture  = (r_state == ROW_CAP);

  pixel_row_buffer #(
    .PIXEL_BITS (PIXEL_BITS),
    .WIDTH      (PIXEL_ARRAY_WIDTH)
  ) u_rowBuffer (
    .clk       (clk),
    .reset     (reset),
    .i_capture (w_capture),
    .i_rowData (data_in),
    .i_col     (r_col),
    .o_pixel   (w_bufPixel)
  );

  // Each conversion step spends one cycle settling the counter (r_phase=0)
  // and one cycle with ramp high, so the counter leads every ramp rise.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_timer     <= '0;
      r_step      <= '0;
      r_phase     <= 1'b0;
      r_row       <= '0;
      r_col       <= '0;
      r_erase     <= 1'b0;
      r_expose    <= 1'b0;
      r_vbn1      <= 1'b0;
      r_read      <= '0;
      r_pixValid  <= 1'b0;
      r_pixLast   <= 1'b0;
      r_frameDone <= 1'b0;
    end else begin
      r_frameDone <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state <= ERASE;
            r_erase <= 1'b1;
            r_timer <= '0;
          end
        end
        ERASE: begin
          if (r_timer == TIMER_W'(ERASE_CYCLES - 1)) begin
            r_state  <= EXPOSE;
            r_erase  <= 1'b0;
            r_expose <= 1'b1;
            r_vbn1   <= 1'b1;
            r_timer  <= '0;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        EXPOSE: begin
          if (r_timer == TIMER_W'(EXPOSE_CYCLES - 1)) begin
            r_state  <= CONVERT;
            r_expose <= 1'b0;
            r_vbn1   <= 1'b0;
            r_timer  <= '0;
            r_step   <= '0;
            r_phase  <= 1'b0;
          end else begin
            r_timer <= r_timer + 1'b1;
            r_vbn1  <= ~r_vbn1;
          end
        end
        CONVERT: begin
          if (!r_phase) begin
            r_phase <= 1'b1;
          end else begin
            r_phase <= 1'b0;
            if (w_stepNext == CONVERT_STEPS) begin
              r_step  <= '0;
              r_state <= ROW_SEL;
              r_row   <= '0;
              r_read  <= PIXEL_ARRAY_HEIGHT'(1);
            end else begin
              r_step <= w_stepNext;
            end
          end
        end
        ROW_SEL: begin
          r_state <= ROW_CAP;
        end
        ROW_CAP: begin
          r_state    <= STREAM;
          r_read     <= '0;
          r_col      <= '0;
          r_pixValid <= 1'b1;
          r_pixLast  <= w_lastRow && (PIXEL_ARRAY_WIDTH == 1);
        end
        STREAM: begin
          // Everything stays frozen until the sink takes the current pixel.
          if (pix_ready) begin
            if (w_lastCol) begin
              r_pixValid <= 1'b0;
              r_pixLast  <= 1'b0;
              r_col      <= '0;
              if (w_lastRow) begin
                r_state     <= IDLE;
                r_row       <= '0;
                r_frameDone <= 1'b1;
              end else begin
                r_state <= ROW_SEL;
                r_row   <= w_rowNext;
                r_read  <= PIXEL_ARRAY_HEIGHT'(1) << w_rowNext;
              end
            end else begin
              r_col     <= w_colNext;
              r_pixLast <= w_lastRow && (w_colNext == COL_W'(PIXEL_ARRAY_WIDTH - 1));
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy       = (r_state != IDLE);
  assign erase      = r_erase;
  assign expose     = r_expose;
  assign vbn1       = r_vbn1;
  assign ramp       = r_phase;
  assign counter    = r_step[PIXEL_BITS-1:0];
  assign read       = r_read;
  assign pix_valid  = r_pixValid;
  assign pix_data   = r_pixValid ? w_bufPixel : '0;
  assign pix_row    = r_row;
  assign pix_col    = r_col;
  assign pix_last   = r_pixLast;
  assign frame_done = r_frameDone;

endmodule
